// File: rtl/mult_acc_pkg.sv
// rtl/mult_acc_pkg.sv - opcodes and latency helper shared by mult_acc_sio and its benches
package mult_acc_pkg;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_ADD   = 2'b01,
        OP_SUB   = 2'b10,
        OP_CLEAR = 2'b11
    } acc_op_e;

    // Edges from the edge that samples VALID_IN to the edge that updates P, plus one.
    function automatic int mult_acc_latency(input int areg, input int breg, input int mreg);
        return ((areg > breg) ? areg : breg) + mreg + 1;
    endfunction

endpackage

// File: rtl/mult_acc_dly.sv
// rtl/mult_acc_dly.sv - clock-enabled delay line with sync reset; depth 0 is a wire
module mult_acc_dly #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_ctrl;
            assign unused_ctrl = &{1'b0, clk, rst, ce};
            assign q = d;
        end else begin : g_reg
            logic [WIDTH-1:0] stage [DEPTH];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
                end else if (ce) begin
                    stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end
            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/mult_acc_sio.sv
// rtl/mult_acc_sio.sv - pipelined signed/unsigned multiply-accumulate slice with B cascade
module mult_acc_sio
    import mult_acc_pkg::*;
#(
    parameter int    A_WIDTH   = 18,
    parameter int    B_WIDTH   = 18,
    parameter int    ACC_WIDTH = 48,
    parameter int    AREG      = 1,
    parameter int    BREG      = 1,
    parameter int    MREG      = 1,
    parameter int    SIGNED    = 1,
    parameter string B_INPUT   = "DIRECT"
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CE,
    input  logic                 VALID_IN,
    input  logic [A_WIDTH-1:0]   A,
    input  logic [B_WIDTH-1:0]   B,
    input  logic [B_WIDTH-1:0]   BCIN,
    input  logic [1:0]           OP,
    output logic [B_WIDTH-1:0]   BCOUT,
    output logic [ACC_WIDTH-1:0] P,
    output logic                 VALID_OUT,
    output logic                 OVF
);

    localparam int D  = (AREG > BREG) ? AREG : BREG;
    localparam int PW = A_WIDTH + B_WIDTH;

    generate
        if (A_WIDTH < 2 || A_WIDTH > 27 || B_WIDTH < 2 || B_WIDTH > 27 || ACC_WIDTH < PW ||
            AREG < 0 || AREG > 2 || BREG < 0 || BREG > 2 || MREG < 0 || MREG > 1 ||
            !(SIGNED == 0 || SIGNED == 1) || !(B_INPUT == "DIRECT" || B_INPUT == "CASCADE"))
        begin : g_bad_param
            $fatal(1, "%m: illegal mult_acc_sio parameter value");
        end
    endgenerate

    logic [B_WIDTH-1:0] b_src, b_al;
    logic [A_WIDTH-1:0] a_al;
    logic [2:0]         ctl_al, ctl_m;
    logic [PW-1:0]      prod, prod_m;
    logic [ACC_WIDTH-1:0] prod_ext;

    assign b_src = (B_INPUT == "CASCADE") ? BCIN : B;

    // B is split so BCOUT taps the true BREG depth; A and control run the full depth D directly.
    mult_acc_dly #(.WIDTH(B_WIDTH), .DEPTH(BREG)) u_b_dly (
        .clk(CLK), .rst(RST), .ce(CE), .d(b_src), .q(BCOUT));
    mult_acc_dly #(.WIDTH(B_WIDTH), .DEPTH(D - BREG)) u_b_pad (
        .clk(CLK), .rst(RST), .ce(CE), .d(BCOUT), .q(b_al));
    mult_acc_dly #(.WIDTH(A_WIDTH), .DEPTH(D)) u_a_dly (
        .clk(CLK), .rst(RST), .ce(CE), .d(A), .q(a_al));
    mult_acc_dly #(.WIDTH(3), .DEPTH(D)) u_ctl_dly (
        .clk(CLK), .rst(RST), .ce(CE), .d({VALID_IN, OP}), .q(ctl_al));

    generate
        if (SIGNED != 0) begin : g_smul
            assign prod     = PW'($signed(a_al)) * PW'($signed(b_al));
            assign prod_ext = ACC_WIDTH'($signed(prod_m));
        end else begin : g_umul
            assign prod     = PW'(a_al) * PW'(b_al);
            assign prod_ext = ACC_WIDTH'(prod_m);
        end
    endgenerate

    logic [PW+2:0] m_d, m_q;
    assign m_d = {ctl_al, prod};
    mult_acc_dly #(.WIDTH(PW + 3), .DEPTH(MREG)) u_m_dly (
        .clk(CLK), .rst(RST), .ce(CE), .d(m_d), .q(m_q));
    assign ctl_m  = m_q[PW+2:PW];
    assign prod_m = m_q[PW-1:0];

    logic [ACC_WIDTH:0] sum_ext, dif_ext;
    logic               ovf_add, ovf_sub;
    logic               p_msb, x_msb;

    assign sum_ext = {1'b0, P} + {1'b0, prod_ext};
    assign dif_ext = {1'b0, P} - {1'b0, prod_ext};
    assign p_msb   = P[ACC_WIDTH-1];
    assign x_msb   = prod_ext[ACC_WIDTH-1];
    // Unsigned overflow is the carry/borrow out; signed uses the operand/result sign rule.
    assign ovf_add = (SIGNED != 0) ? ((p_msb == x_msb) && (sum_ext[ACC_WIDTH-1] != p_msb))
                                   : sum_ext[ACC_WIDTH];
    assign ovf_sub = (SIGNED != 0) ? ((p_msb != x_msb) && (dif_ext[ACC_WIDTH-1] != p_msb))
                                   : dif_ext[ACC_WIDTH];

    always_ff @(posedge CLK) begin
        if (RST) begin
            P         <= '0;
            VALID_OUT <= 1'b0;
            OVF       <= 1'b0;
        end else if (CE) begin
            VALID_OUT <= ctl_m[2];
            if (ctl_m[2]) begin
                case (ctl_m[1:0])
                    OP_LOAD: begin
                        P   <= prod_ext;
                        OVF <= 1'b0;
                    end
                    OP_ADD: begin
                        P   <= sum_ext[ACC_WIDTH-1:0];
                        OVF <= OVF | ovf_add;
                    end
                    OP_SUB: begin
                        P   <= dif_ext[ACC_WIDTH-1:0];
                        OVF <= OVF | ovf_sub;
                    end
                    default: begin
                        P   <= '0;
                        OVF <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
